// File: rtl/pf_lanectrl_pause_pkg.sv
// ============================================================================
// pf_lanectrl_pause_pkg : shared types and limits for the pause sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package pf_lanectrl_pause_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_MOVE  = 3'd2,
        ST_GAP   = 3'd3,
        ST_POST  = 3'd4,
        ST_GUARD = 3'd5
    } pause_state_e;

    localparam int TIMER_W = 4;

    localparam int PRE_MIN  = 3;
    localparam int PRE_MAX  = 15;
    localparam int GAP_MIN  = 0;
    localparam int GAP_MAX  = 15;
    localparam int POST_MIN = 1;
    localparam int POST_MAX = 15;
    localparam int IDLE_MIN = 0;
    localparam int IDLE_MAX = 15;

    function automatic bit in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pf_lanectrl_cycle_timer.sv
// ============================================================================
// pf_lanectrl_cycle_timer : loadable down-counter with zero flag
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pf_lanectrl_cycle_timer
    import pf_lanectrl_pause_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over count; the counter parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/pf_lanectrl_pause_seq.sv
// ============================================================================
// pf_lanectrl_pause_seq : pauses the HS IO clock around IOG delay-line moves
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pf_lanectrl_pause_seq
    import pf_lanectrl_pause_pkg::*;
#(
    parameter int STEP_W            = 7,
    parameter int PRE_PAUSE_CYCLES  = 4,
    parameter int MOVE_GAP          = 2,
    parameter int POST_PAUSE_CYCLES = 4,
    parameter int MIN_IDLE          = 2,
    parameter bit ENABLE_PAUSE      = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              UPD_REQ,
    input  logic              UPD_DIR,
    input  logic [STEP_W-1:0] UPD_STEPS,
    output logic              BUSY,
    output logic              UPD_DONE,
    output logic              HS_IO_CLK_PAUSE,
    output logic              DELAY_MOVE,
    output logic              DELAY_DIR
);

    generate
        if (STEP_W < 1) begin : g_chk_step_w
            $error("STEP_W must be at least 1");
        end
        if (!in_range(PRE_PAUSE_CYCLES, PRE_MIN, PRE_MAX)) begin : g_chk_pre
            $error("PRE_PAUSE_CYCLES out of range");
        end
        if (!in_range(MOVE_GAP, GAP_MIN, GAP_MAX)) begin : g_chk_gap
            $error("MOVE_GAP out of range");
        end
        if (!in_range(POST_PAUSE_CYCLES, POST_MIN, POST_MAX)) begin : g_chk_post
            $error("POST_PAUSE_CYCLES out of range");
        end
        if (!in_range(MIN_IDLE, IDLE_MIN, IDLE_MAX)) begin : g_chk_idle
            $error("MIN_IDLE out of range");
        end
    endgenerate

    // GUARD also covers the release/done cycle, hence MIN_IDLE rather than MIN_IDLE-1.
    localparam logic [TIMER_W-1:0] c_pre_load   = TIMER_W'(PRE_PAUSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_gap_load   = TIMER_W'(MOVE_GAP - 1);
    localparam logic [TIMER_W-1:0] c_post_load  = TIMER_W'(POST_PAUSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_guard_load = TIMER_W'(MIN_IDLE);

    pause_state_e      state_q,  state_d;
    logic [STEP_W-1:0] steps_q,  steps_d;
    logic              dir_q,    dir_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              pause_q,  pause_d;
    logic              move_q,   move_d;

    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_val;
    logic               w_tmr_en;
    logic               w_tmr_zero;

    pf_lanectrl_cycle_timer #(
        .WIDTH      (TIMER_W)
    ) u_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        steps_d    = steps_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (UPD_REQ) begin
                    if (UPD_STEPS != '0) begin
                        steps_d    = UPD_STEPS;
                        dir_d      = UPD_DIR;
                        state_d    = ST_PRE;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_pre_load;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_PRE: begin
                if (w_tmr_zero) begin
                    state_d = ST_MOVE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            ST_MOVE: begin
                steps_d = steps_q - STEP_W'(1);
                if (steps_q == STEP_W'(1)) begin
                    state_d    = ST_POST;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_post_load;
                end else if (MOVE_GAP == 0) begin
                    state_d = ST_MOVE;
                end else begin
                    state_d    = ST_GAP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_gap_load;
                end
            end

            ST_GAP: begin
                if (w_tmr_zero) begin
                    state_d = ST_MOVE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            ST_POST: begin
                if (w_tmr_zero) begin
                    done_d = 1'b1;
                    if (MIN_IDLE == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_GUARD;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_guard_load;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            ST_GUARD: begin
                if (w_tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are flop outputs aligned with it.
        busy_d  = (state_d != ST_IDLE);
        pause_d = ENABLE_PAUSE && (state_d inside {ST_PRE, ST_MOVE, ST_GAP, ST_POST});
        move_d  = (state_d == ST_MOVE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            steps_q <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pause_q <= 1'b0;
            move_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pause_q <= pause_d;
            move_q  <= move_d;
        end
    end

    assign BUSY            = busy_q;
    assign UPD_DONE        = done_q;
    assign HS_IO_CLK_PAUSE = pause_q;
    assign DELAY_MOVE      = move_q;
    assign DELAY_DIR       = dir_q;

endmodule

`default_nettype wire

// File: tb/tb_pf_lanectrl_pause_seq.sv
// ============================================================================
// tb_pf_lanectrl_pause_seq : scoreboard bench over four parameter sets
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pf_lanectrl_pause_seq;

    localparam int NI     = 4;
    localparam int STEP_W = 7;

    localparam int PRE_A  [NI] = '{4, 4, 4, 3};
    localparam int GAP_A  [NI] = '{2, 0, 2, 1};
    localparam int POST_A [NI] = '{4, 4, 4, 1};
    localparam int MIN_A  [NI] = '{2, 0, 2, 15};
    localparam int EN_A   [NI] = '{1, 1, 0, 1};

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              UPD_REQ = 1'b0;
    logic              UPD_DIR = 1'b0;
    logic [STEP_W-1:0] UPD_STEPS = '0;

    logic [NI-1:0] busy, done, pause, mv, ddir;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            pf_lanectrl_pause_seq #(
                .STEP_W            (STEP_W),
                .PRE_PAUSE_CYCLES  (PRE_A[g]),
                .MOVE_GAP          (GAP_A[g]),
                .POST_PAUSE_CYCLES (POST_A[g]),
                .MIN_IDLE          (MIN_A[g]),
                .ENABLE_PAUSE      (EN_A[g] != 0)
            ) u_dut (
                .CLK             (CLK),
                .RESET           (RESET),
                .UPD_REQ         (UPD_REQ),
                .UPD_DIR         (UPD_DIR),
                .UPD_STEPS       (UPD_STEPS),
                .BUSY            (busy[g]),
                .UPD_DONE        (done[g]),
                .HS_IO_CLK_PAUSE (pause[g]),
                .DELAY_MOVE      (mv[g]),
                .DELAY_DIR       (ddir[g])
            );
        end
    endgenerate

    typedef struct {
        int cyc;
        int dir;
    } ev_t;

    ev_t move_q [NI][$];
    int  done_q [NI][$];
    int  pause_lo [NI], pause_hi [NI];
    int  busy_lo  [NI], busy_hi  [NI];
    int  next_ok  [NI];
    int  dir_old  [NI], dir_new  [NI], dir_chg [NI];

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cycle=%0d got=%0d expected=%0d", name, inst, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            move_q[i].delete();
            done_q[i].delete();
            pause_lo[i] = 1;  pause_hi[i] = 0;
            busy_lo[i]  = 1;  busy_hi[i]  = 0;
            next_ok[i]  = 0;
            dir_old[i]  = 0;  dir_new[i]  = 0;  dir_chg[i] = 0;
        end
    endtask

    // Reference timeline for a request presented during cycle n.
    task automatic model_issue(input int n, input bit req, input bit dir, input int steps);
        int first_mv, last_mv, d;
        for (int i = 0; i < NI; i++) begin
            if (req && n >= next_ok[i]) begin
                if (steps == 0) begin
                    done_q[i].push_back(n + 1);
                end else begin
                    first_mv = n + 1 + PRE_A[i];
                    last_mv  = first_mv + (steps - 1) * (GAP_A[i] + 1);
                    for (int k = 0; k < steps; k++) begin
                        move_q[i].push_back('{cyc: first_mv + k * (GAP_A[i] + 1), dir: int'(dir)});
                    end
                    pause_lo[i] = n + 1;
                    pause_hi[i] = last_mv + POST_A[i];
                    d           = pause_hi[i] + 1;
                    done_q[i].push_back(d);
                    busy_lo[i]  = n + 1;
                    busy_hi[i]  = (MIN_A[i] == 0) ? d - 1 : d + MIN_A[i];
                    next_ok[i]  = busy_hi[i] + 1;
                    dir_old[i]  = dir_new[i];
                    dir_new[i]  = int'(dir);
                    dir_chg[i]  = n + 1;
                end
            end
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++) begin
            if (move_q[i].size() != 0 || done_q[i].size() != 0 || cyc < next_ok[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick(input bit req, input bit dir, input int steps);
        @(posedge CLK);
        #1;
        UPD_REQ   = req;
        UPD_DIR   = dir;
        UPD_STEPS = STEP_W'(steps);
        if (!RESET) model_issue(cyc, req, dir, steps);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!all_idle() && k < budget) begin
            tick(1'b0, 1'b0, 0);
            k++;
        end
        chk("idle_within_budget", -1, int'(all_idle()), 1);
    endtask

    // Reset lands a few ns into a cycle so the outputs can be seen falling before any edge.
    task automatic do_reset(input int ncyc);
        @(posedge CLK);
        #3;
        RESET   = 1'b1;
        UPD_REQ = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_rst_pause", i, int'(pause[i]), 0);
            chk("async_rst_busy",  i, int'(busy[i]),  0);
            chk("async_rst_move",  i, int'(mv[i]),    0);
            chk("async_rst_done",  i, int'(done[i]),  0);
        end
        repeat (ncyc) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    // Monitor: pops an expected event whenever the DUT strobes or one falls due.
    always @(negedge CLK) begin
        ev_t ev;
        int  dexp;
        for (int i = 0; i < NI; i++) begin
            if (mv[i] || (move_q[i].size() > 0 && move_q[i][0].cyc <= cyc)) begin
                if (move_q[i].size() == 0) begin
                    chk("move_unexpected", i, cyc, -1);
                end else begin
                    ev = move_q[i].pop_front();
                    chk("move_cycle", i, mv[i] ? cyc : -1, ev.cyc);
                    chk("move_dir", i, int'(ddir[i]), ev.dir);
                end
            end
            if (done[i] || (done_q[i].size() > 0 && done_q[i][0] <= cyc)) begin
                if (done_q[i].size() == 0) begin
                    chk("done_unexpected", i, cyc, -1);
                end else begin
                    dexp = done_q[i].pop_front();
                    chk("done_cycle", i, done[i] ? cyc : -1, dexp);
                end
            end
            chk("pause", i, int'(pause[i]),
                (EN_A[i] != 0 && cyc >= pause_lo[i] && cyc <= pause_hi[i]) ? 1 : 0);
            chk("busy", i, int'(busy[i]), (cyc >= busy_lo[i] && cyc <= busy_hi[i]) ? 1 : 0);
            chk("delay_dir", i, int'(ddir[i]), (cyc >= dir_chg[i]) ? dir_new[i] : dir_old[i]);
        end
    end

    initial begin
        int r, st;
        model_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Basic 3-step sequence, DIR=1
        tick(1'b1, 1'b1, 3);
        wait_idle(200);

        // Zero-step request
        tick(1'b1, 1'b0, 0);
        repeat (3) tick(1'b0, 1'b0, 0);

        // Requests while busy are ignored; then a held request re-arms on the first idle cycle
        tick(1'b1, 1'b0, 4);
        repeat (4) tick(1'b0, 1'b1, 0);
        repeat (3) tick(1'b1, 1'b1, 5);
        repeat (45) tick(1'b1, 1'b0, 3);
        wait_idle(200);

        // Reset in the middle of the first gap
        tick(1'b1, 1'b1, 3);
        repeat (8) tick(1'b0, 1'b0, 0);
        do_reset(2);
        tick(1'b1, 1'b0, 3);
        wait_idle(200);

        // Full-scale step count
        tick(1'b1, 1'b1, 127);
        wait_idle(1000);

        // Randomised traffic
        repeat (400) begin
            r  = $urandom_range(0, 3);
            st = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9);
            tick(r == 0, 1'($urandom_range(0, 1)), st);
        end
        tick(1'b0, 1'b0, 0);
        wait_idle(3000);

        for (int i = 0; i < NI; i++) begin
            chk("move_q_left", i, move_q[i].size(), 0);
            chk("done_q_left", i, done_q[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pf_lanectrl_pause_seq.md
Name: pf_lanectrl_pause_seq

Overview:
- Upstream neighbour of the lane-control pause synchroniser.
- Accepts delay-update requests from the per-lane training logic and sequences them safely:
  - raises HS_IO_CLK_PAUSE;
  - waits a settle interval;
  - issues N single-cycle delay-move pulses;
  - holds pause for a post interval, then releases and signals completion.
- HS_IO_CLK_PAUSE feeds the pause synchroniser (0-2 cycles of further latency), so PRE_PAUSE_CYCLES covers that latency.

Parameters:
- STEP_W, 7, width of step-count request.
- PRE_PAUSE_CYCLES, 4, cycles pause is high before the first move; legal range 3..15.
- MOVE_GAP, 2, low cycles between consecutive move pulses; legal range 0..15.
- POST_PAUSE_CYCLES, 4, cycles pause stays high after the last move; legal range 1..15.
- MIN_IDLE, 2, guard cycles after release before a new request is accepted; legal range 0..15.
- ENABLE_PAUSE, 1, 0 = HS_IO_CLK_PAUSE tied low; all other timing unchanged.

Ports:
- CLK  in  1  lane control clock.
- RESET  in  1  asynchronous, active-high reset.
- UPD_REQ  in  1  request pulse/level, sampled only in IDLE.
- UPD_DIR  in  1  move direction, latched with the request.
- UPD_STEPS  in  STEP_W  number of moves, latched with the request.
- BUSY  out  1  high from the cycle after acceptance until return to IDLE.
- UPD_DONE  out  1  one-cycle completion pulse.
- HS_IO_CLK_PAUSE  out  1  pause request to the pause synchroniser.
- DELAY_MOVE  out  1  one-cycle move strobe to the IOG delay line.
- DELAY_DIR  out  1  latched direction; stable whenever BUSY is high.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; counters = 0. Reset is asynchronous and takes effect mid-sequence: pause drops immediately and no UPD_DONE is issued.
- States: IDLE, PRE, MOVE, GAP, POST, GUARD. All outputs are registered.
- IDLE:
  - UPD_REQ=1 at edge T with UPD_STEPS>0: latch steps and direction.
  - From T+1: BUSY=1, HS_IO_CLK_PAUSE=1 (if ENABLE_PAUSE), go to PRE.
  - UPD_REQ=1 with UPD_STEPS=0: no pause, no moves; BUSY=0; UPD_DONE=1 for the single cycle after T; stay in IDLE.
- PRE: holds PRE_PAUSE_CYCLES cycles, then MOVE.
- MOVE:
  - DELAY_MOVE=1 for exactly one cycle; remaining count decrements.
  - Remaining>0 after decrement: go to GAP (if MOVE_GAP=0, go straight back to MOVE, giving back-to-back pulses).
  - Otherwise go to POST.
- GAP: MOVE_GAP cycles with DELAY_MOVE=0, then MOVE.
- POST: POST_PAUSE_CYCLES cycles with pause high and no moves.
- Leaving POST:
  - HS_IO_CLK_PAUSE=0 and UPD_DONE=1 in the same cycle.
  - Go to GUARD, which holds MIN_IDLE cycles with BUSY=1, then IDLE with BUSY=0.
  - If MIN_IDLE=0, go straight to IDLE; BUSY falls together with the UPD_DONE pulse.
- Pause-high duration for N moves = PRE + N + (N-1)*MOVE_GAP + POST cycles.
- First move rises at T+1+PRE_PAUSE_CYCLES.
- UPD_REQ while BUSY is ignored (not queued). A level-held request is re-accepted in the first IDLE cycle.
- UPD_DIR/UPD_STEPS changes while BUSY have no effect.
- Counters:
  - Step counter is STEP_W bits; max request 2^STEP_W-1 completes without wrap.
  - Interval timer is 4 bits, loaded with the interval minus 1 and counted down to 0.
- DELAY_MOVE is never high while HS_IO_CLK_PAUSE is low (when ENABLE_PAUSE=1).

Decomposition:
- Package pf_lanectrl_pause_pkg:
  - state enumeration (IDLE, PRE, MOVE, GAP, POST, GUARD);
  - TIMER_W=4;
  - parameter range limits, used by elaboration-time checks.
- Sub-module pf_lanectrl_cycle_timer:
  - loadable 4-bit down-counter with load, enable and a zero flag;
  - shared by the PRE, GAP, POST and GUARD intervals.

Test Plan:
- Defaults, REQ at T with STEPS=3, DIR=1 -> pause high T+1..T+15 (15 cycles); moves at T+5, T+8, T+11; DONE at T+16 with pause low; BUSY low from T+19; DELAY_DIR=1 throughout.
- STEPS=0 -> UPD_DONE at T+1 only; pause, DELAY_MOVE and BUSY stay 0.
- MOVE_GAP=0, STEPS=4 -> four contiguous move pulses T+5..T+8; pause high 12 cycles.
- Second REQ during BUSY (and DIR toggled) -> ignored; exactly 3 moves, DIR unchanged; REQ held high -> new sequence starts the first IDLE cycle after GUARD.
- RESET asserted at T+9 (mid-GAP) -> pause, BUSY and MOVE low asynchronously; no DONE; next REQ after release runs a full, correct sequence.
- STEPS=127 -> exactly 127 pulses, no wrap; DONE once; ENABLE_PAUSE=0 run -> identical move timing, pause constant 0.
